// File: rtl/sw_accumulator_display_if.sv
// Board-facing signal bundle for the switch/key calculator: switches and keys in, LEDs and HEX out.
interface sw_accumulator_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [9:0]              SW;
  logic [1:0]              KEY;
  logic [9:0]              LEDR;
  logic [8*NUM_DIGITS-1:0] HEX;

  modport master (output SW, KEY, input LEDR, HEX);
  modport slave  (input SW, KEY, output LEDR, HEX);
endinterface

// File: rtl/sw_accumulator_display.sv
// Sequential hex calculator: debounced keys execute SW opcodes into an accumulator,
// the result or the live operand is shown on seven-segment digits with flags on LEDR.
module sw_accumulator_display_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync;
  logic [1:0]    vld_pipe;
  logic          armed_q;
  logic          press_d;
  logic          synced;

  assign synced = sync[1];

  // A key already held through reset must be seen released before it can arm;
  // vld_pipe marks when the synchroniser holds real samples instead of reset ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      vld_pipe <= 2'b00;
      armed_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], key_n};
      vld_pipe <= {vld_pipe[0], 1'b1};
      armed_q  <= armed_q | (vld_pipe[1] & synced);
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      press    <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE:
        if (!synced && armed_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = CW'(1);
        end
      WAIT_PRESS:
        if (synced) state_d = IDLE;
        else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      PRESSED:
        if (synced) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CW'(1);
        end
      WAIT_RELEASE:
        if (!synced) state_d = PRESSED;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
endmodule

module sw_accumulator_display #(
  parameter int OPERAND_W       = 8,
  parameter int ACC_W           = 16,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                      MAX10_CLK1_50,
  input logic                      RST,
  sw_accumulator_display_if.slave  io
);
  localparam int HEX_W = 4 * NUM_DIGITS;

  function automatic logic [8*NUM_DIGITS-1:0] hex_rst_f();
    logic [8*NUM_DIGITS-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[8*i +: 8] = (4*i >= ACC_W) ? 8'hFF : 8'hC0;
    return r;
  endfunction
  localparam logic [8*NUM_DIGITS-1:0] HEX_RST = hex_rst_f();

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h40; 4'h1: seg = 7'h79; 4'h2: seg = 7'h24; 4'h3: seg = 7'h30;
      4'h4: seg = 7'h19; 4'h5: seg = 7'h12; 4'h6: seg = 7'h02; 4'h7: seg = 7'h78;
      4'h8: seg = 7'h00; 4'h9: seg = 7'h10; 4'hA: seg = 7'h08; 4'hB: seg = 7'h03;
      4'hC: seg = 7'h46; 4'hD: seg = 7'h21; 4'hE: seg = 7'h06; default: seg = 7'h0E;
    endcase
  endfunction

  logic [1:0]                    press;
  logic [ACC_W-1:0]              op_ext, op_q, acc_q, acc_d;
  logic [ACC_W:0]                sum, diff;
  logic                          carry_q, carry_d, zero_q, show_op_q;
  logic [7:0]                    opcount_q, opcount_d;
  logic [HEX_W-1:0]              src;
  logic [NUM_DIGITS-1:0][7:0]    hex_d, hex_q;

  sw_accumulator_display_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clk   (MAX10_CLK1_50),
    .rst   (RST),
    .key_n (io.KEY),
    .press (press)
  );

  assign op_ext = ACC_W'(io.SW[OPERAND_W-1:0]);
  assign sum    = {1'b0, acc_q} + {1'b0, op_ext};
  assign diff   = {1'b0, acc_q} - {1'b0, op_ext};

  always_comb begin
    acc_d     = acc_q;
    carry_d   = carry_q;
    opcount_d = opcount_q + 8'd1;
    case (io.SW[9:8])
      2'b00: begin acc_d = sum[ACC_W-1:0];  carry_d = sum[ACC_W];  end
      2'b01: begin acc_d = diff[ACC_W-1:0]; carry_d = diff[ACC_W]; end
      2'b10: begin acc_d = op_ext;          carry_d = 1'b0;        end
      default: begin
        acc_d     = '0;
        carry_d   = 1'b0;
        opcount_d = '0;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      acc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      opcount_q <= '0;
      show_op_q <= 1'b0;
      op_q      <= '0;
    end else begin
      op_q <= op_ext;
      if (press[0]) begin
        acc_q     <= acc_d;
        carry_q   <= carry_d;
        zero_q    <= (acc_d == '0);
        opcount_q <= opcount_d;
      end
      if (press[1]) show_op_q <= ~show_op_q;
    end
  end

  // Display reads registered state only, so HEX trails the accumulator by one edge.
  assign src = HEX_W'(show_op_q ? op_q : acc_q);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (4*i >= ACC_W) begin : g_blank
      assign hex_d[i] = 8'hFF;
    end else begin : g_seg
      assign hex_d[i] = {~(show_op_q && (i == 0)), seg(src[4*i +: 4])};
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) hex_q <= HEX_RST;
    else     hex_q <= hex_d;
  end

  assign io.HEX  = hex_q;
  assign io.LEDR = {zero_q, carry_q, opcount_q};
endmodule
